// File: rtl/chunked_adder_defs.sv
// Shared definitions for the chunked serial adder: state encoding and
// parameter helper functions.
package chunked_adder_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int sel_width(input int nchunk);
        return (clog2(nchunk) < 1) ? 1 : clog2(nchunk);
    endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit ripple adder; exposes the carry out of every bit
// so the caller can pick the true carry of a partially filled top chunk.
module chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic [CHUNK-1:0] cvec
);

    always_comb begin
        logic cc;
        s    = '0;
        cvec = '0;
        cc   = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]    = a[i] ^ b[i] ^ cc;
            cc      = (a[i] & b[i]) | (cc & (a[i] ^ b[i]));
            cvec[i] = cc;
        end
    end

    assign cout = cvec[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Chunk-loaded operands, serial LSB-first add one CHUNK per clock.
// Optional macro SUBTRACT_EN adds a sub input selecting A + ~B + 1.
//
//   state | meaning
//   IDLE  | waiting; loads and start accepted
//   BUSY  | adding chunk idx each clock; loads/start ignored
//   DONE  | sum/carry valid and held; a load returns to IDLE
module chunked_serial_adder
    import chunked_adder_defs::*;
#(
    parameter  int WIDTH  = 7,
    parameter  int CHUNK  = 4,
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK,
    localparam int SELW   = sel_width(NCHUNK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic [SELW-1:0]  sel,
    input  logic [CHUNK-1:0] din,
    input  logic             start,
`ifdef SUBTRACT_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam int PADW  = NCHUNK * CHUNK;
    localparam int TOPW  = WIDTH - (NCHUNK - 1) * CHUNK;
    localparam int LASTC = (WIDTH - 1) % CHUNK;
    localparam logic [CHUNK-1:0] TOP_MASK = {CHUNK{1'b1}} >> (CHUNK - TOPW);

    state_t state, state_nx;

    logic ld_a_q, ld_b_q, start_q;
    logic ld_a_rise, ld_b_rise, start_rise;
    logic [PADW-1:0]  a_reg, b_reg, work, work_nx;
    logic [SELW-1:0]  idx;
    logic             c;
    logic             accept, sel_ok, is_last;
    logic [CHUNK-1:0] ld_data, a_chunk, b_chunk, b_op, s_chunk, cvec;
    logic             cout;
    logic             unused_cvec;

    assign ld_a_rise  = ld_a & ~ld_a_q;
    assign ld_b_rise  = ld_b & ~ld_b_q;
    assign start_rise = start & ~start_q;

    assign accept  = (state != BUSY);
    assign sel_ok  = (32'(sel) < 32'(NCHUNK));
    assign is_last = (32'(idx) == 32'(NCHUNK - 1));
    // Padding bits of the top chunk are kept zero so they never leak into sum.
    assign ld_data = (32'(sel) == 32'(NCHUNK - 1)) ? (din & TOP_MASK) : din;

    assign a_chunk = a_reg[32'(idx) * CHUNK +: CHUNK];
    assign b_chunk = b_reg[32'(idx) * CHUNK +: CHUNK];

`ifdef SUBTRACT_EN
    logic sub_q;
    assign b_op = b_chunk ^ {CHUNK{sub_q}};
`else
    assign b_op = b_chunk;
`endif

    chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
        .a    (a_chunk),
        .b    (b_op),
        .cin  (c),
        .s    (s_chunk),
        .cout (cout),
        .cvec (cvec)
    );

    assign unused_cvec = ^cvec;

    always_comb begin
        work_nx = work;
        work_nx[32'(idx) * CHUNK +: CHUNK] = s_chunk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_rise) state_nx = BUSY;
            BUSY: if (is_last)    state_nx = DONE;
            DONE: begin
                if (start_rise)                  state_nx = BUSY;
                else if (ld_a_rise || ld_b_rise) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_a_q  <= 1'b0;
            ld_b_q  <= 1'b0;
            start_q <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            work    <= '0;
            idx     <= '0;
            c       <= 1'b0;
            sum     <= '0;
            carry   <= 1'b0;
`ifdef SUBTRACT_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            ld_a_q  <= ld_a;
            ld_b_q  <= ld_b;
            start_q <= start;
            if (accept && ld_a_rise && sel_ok)
                a_reg[32'(sel) * CHUNK +: CHUNK] <= ld_data;
            if (accept && ld_b_rise && sel_ok)
                b_reg[32'(sel) * CHUNK +: CHUNK] <= ld_data;
            if (accept && start_rise) begin
                idx  <= '0;
                work <= '0;
`ifdef SUBTRACT_EN
                c     <= sub;
                sub_q <= sub;
`else
                c     <= 1'b0;
`endif
            end else if (state == BUSY) begin
                work <= work_nx;
                idx  <= idx + 1'b1;
                c    <= cout;
                if (is_last) begin
                    sum   <= work_nx[WIDTH-1:0];
                    carry <= cvec[LASTC];
                end
            end
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder: three parameterisations
// share one stimulus bus; an integer-level operand model predicts results.
module tb_chunked_serial_adder;

    logic       clk = 1'b0;
    logic       rst, ld_a, ld_b, start;
    logic [1:0] sel;
    logic [3:0] din;
`ifdef SUBTRACT_EN
    logic       sub;
    logic [7:0] sum8;
    logic       carry8, busy8, done8;
`endif

    logic [6:0]  sum74, sum73;
    logic [15:0] sum16;
    logic        carry74, busy74, done74;
    logic        carry16, busy16, done16;
    logic        carry73, busy73, done73;

    int n_chk  = 0;
    int n_fail = 0;

    // model state per instance: 0 = W7/C4, 1 = W16/C4, 2 = W7/C3
    int ma [3];
    int mb [3];
    int mw [3] = '{7, 16, 7};
    int mc [3] = '{4, 4, 3};
    int mn [3] = '{2, 4, 3};

    always #5 clk = ~clk;

    chunked_serial_adder #(.WIDTH(7), .CHUNK(4)) u74 (
        .clk(clk), .rst(rst), .ld_a(ld_a), .ld_b(ld_b), .sel(sel[0]), .din(din),
        .start(start),
`ifdef SUBTRACT_EN
        .sub(sub),
`endif
        .sum(sum74), .carry(carry74), .busy(busy74), .done(done74));

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk(clk), .rst(rst), .ld_a(ld_a), .ld_b(ld_b), .sel(sel), .din(din),
        .start(start),
`ifdef SUBTRACT_EN
        .sub(sub),
`endif
        .sum(sum16), .carry(carry16), .busy(busy16), .done(done16));

    chunked_serial_adder #(.WIDTH(7), .CHUNK(3)) u73 (
        .clk(clk), .rst(rst), .ld_a(ld_a), .ld_b(ld_b), .sel(sel), .din(din[2:0]),
        .start(start),
`ifdef SUBTRACT_EN
        .sub(sub),
`endif
        .sum(sum73), .carry(carry73), .busy(busy73), .done(done73));

`ifdef SUBTRACT_EN
    chunked_serial_adder #(.WIDTH(8), .CHUNK(4)) u8 (
        .clk(clk), .rst(rst), .ld_a(ld_a), .ld_b(ld_b), .sel(sel[0]), .din(din),
        .start(start), .sub(sub),
        .sum(sum8), .carry(carry8), .busy(busy8), .done(done8));
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic        c;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] get_sum(input int k);
        case (k)
            0:       return 32'(sum74);
            1:       return 32'(sum16);
            default: return 32'(sum73);
        endcase
    endfunction

    function automatic logic get_carry(input int k);
        case (k)
            0:       return carry74;
            1:       return carry16;
            default: return carry73;
        endcase
    endfunction

    function automatic int upd(input int old, input int k, input int s, input int d);
        int m;
        if (s >= mn[k]) return old;
        m = ((1 << mc[k]) - 1) << (s * mc[k]);
        return ((old & ~m) | ((d & ((1 << mc[k]) - 1)) << (s * mc[k]))) & ((1 << mw[k]) - 1);
    endfunction

    task automatic model_load(input bit to_b, input int s, input int d);
        for (int k = 0; k < 3; k++) begin
            int sk;
            sk = (k == 0) ? (s & 1) : (s & 3);
            if (to_b) mb[k] = upd(mb[k], k, sk, d);
            else      ma[k] = upd(ma[k], k, sk, d);
        end
    endtask

    task automatic check_all(input string name);
        for (int k = 0; k < 3; k++) begin
            int total;
            total = ma[k] + mb[k];
            check($sformatf("%s_sum%0d", name, k), get_sum(k), 32'(total & ((1 << mw[k]) - 1)));
            check($sformatf("%s_carry%0d", name, k), 32'(get_carry(k)), 32'((total >> mw[k]) & 1));
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1; ld_a = 1'b0; ld_b = 1'b0; start = 1'b0; sel = 2'd0; din = 4'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin ma[k] = 0; mb[k] = 0; end
        @(posedge clk); #1;
    endtask

    task automatic load(input bit to_b, input int s, input int d);
        sel = s[1:0];
        din = d[3:0];
        if (to_b) ld_b = 1'b1;
        else      ld_a = 1'b1;
        @(posedge clk); #1;
        ld_a = 1'b0;
        ld_b = 1'b0;
        @(posedge clk); #1;
        model_load(to_b, s, d);
    endtask

    task automatic load_word16(input bit to_b, input logic [15:0] v);
        for (int i = 0; i < 4; i++) load(to_b, i, int'((v >> (4 * i)) & 16'hF));
    endtask

    // Pulses start and counts edges (including the sampling edge) until
    // the W16 instance reports done, which is the slowest of the three.
    task automatic run(output int edges, output int bcyc);
        bit got;
        got = 1'b0; edges = 0; bcyc = 0;
        start = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            edges++;
            if (busy16) bcyc++;
            if (done16) got = 1'b1;
        end
        if (!got) check("run_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done16();
        bit got;
        got = done16;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (done16) got = 1'b1;
        end
        if (!got) check("wait_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        vec_t vt [7];
        int e, bc;

        rst = 1'b1; ld_a = 1'b0; ld_b = 1'b0; start = 1'b0; sel = 2'd0; din = 4'd0;
`ifdef SUBTRACT_EN
        sub = 1'b0;
`endif
        vt[0] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        vt[1] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
        vt[2] = '{16'h1234, 16'h4321, 16'h5555, 1'b0};
        vt[3] = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
        vt[4] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
        vt[5] = '{16'h0F0F, 16'h00F1, 16'h1000, 1'b0};
        vt[6] = '{16'hABCD, 16'h1234, 16'hBE01, 1'b0};

        #2;
        check("rst_sum74", 32'(sum74), 32'd0);
        check("rst_sum16", 32'(sum16), 32'd0);
        check("rst_carry74", 32'(carry74), 32'd0);
        check("rst_busy74", 32'(busy74), 32'd0);
        check("rst_done74", 32'(done74), 32'd0);
        check("rst_done16", 32'(done16), 32'd0);
        reset_dut();

        // Default parameters, hand-checked latency
        load(0, 0, 4'hD); load(0, 1, 4'h6); load(1, 0, 4'hE); load(1, 1, 4'h5);
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        check("lat_e1_busy", 32'(busy74), 32'd1);
        check("lat_e1_done", 32'(done74), 32'd0);
        @(posedge clk); #1;
        check("lat_e2_done", 32'(done74), 32'd0);
        @(posedge clk); #1;
        check("lat_e3_done", 32'(done74), 32'd1);
        check("lat_e3_busy", 32'(busy74), 32'd0);
        check("def_sum", 32'(sum74), 32'h4B);
        check("def_carry", 32'(carry74), 32'd1);
        wait_done16();
        check_all("def");

        // W16 vector table
        for (int i = 0; i < 7; i++) begin
            load_word16(0, vt[i].a);
            load_word16(1, vt[i].b);
            run(e, bc);
            check($sformatf("tbl%0d_sum", i), 32'(sum16), 32'(vt[i].s));
            check($sformatf("tbl%0d_carry", i), 32'(carry16), 32'(vt[i].c));
            check($sformatf("tbl%0d_edges", i), 32'(e), 32'd5);
            check($sformatf("tbl%0d_busy", i), 32'(bc), 32'd4);
            check_all($sformatf("tbl%0d", i));
        end

        // Held strobe writes once
        reset_dut();
        sel = 2'd0; din = 4'd3; ld_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            din = (4 + i > 9) ? 4'd9 : 4'(4 + i);
        end
        ld_a = 1'b0;
        @(posedge clk); #1;
        model_load(0, 0, 3);
        run(e, bc);
        check("hold_sum74", 32'(sum74), 32'd3);
        check("hold_sum16", 32'(sum16), 32'd3);
        check("hold_sum73", 32'(sum73), 32'd3);
        check_all("hold");

        // sel beyond NCHUNK leaves the operand alone (W7/C3: NCHUNK=3)
        reset_dut();
        load(0, 0, 5);
        load(0, 3, 7);
        run(e, bc);
        check("selrange_sum73", 32'(sum73), 32'd5);
        check_all("selrange");

        // Load and restart during BUSY are ignored; load in DONE returns to IDLE
        reset_dut();
        load(0, 0, 4'hD); load(0, 1, 4'h6); load(1, 0, 4'hE); load(1, 1, 4'h5);
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        sel = 2'd0; din = 4'd0; ld_b = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        check("midbusy_done", 32'(done74), 32'd1);
        check("midbusy_sum", 32'(sum74), 32'h4B);
        check("midbusy_carry", 32'(carry74), 32'd1);
        ld_b = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        ld_b = 1'b1;
        @(posedge clk); #1;
        ld_b = 1'b0;
        check("doneload_done", 32'(done74), 32'd0);
        check("doneload_busy", 32'(busy74), 32'd0);
        check("doneload_sum", 32'(sum74), 32'h4B);
        run(e, bc);
        check("doneload_newsum", 32'(sum74), 32'h3D);
        check("doneload_newcarry", 32'(carry74), 32'd1);

        // Asynchronous reset in the second BUSY cycle
        reset_dut();
        load_word16(0, 16'h1234);
        load_word16(1, 16'h1111);
        run(e, bc);
        check("prerst_sum16", 32'(sum16), 32'h2345);
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_sum16", 32'(sum16), 32'd0);
        check("arst_carry16", 32'(carry16), 32'd0);
        check("arst_busy16", 32'(busy16), 32'd0);
        check("arst_done16", 32'(done16), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin ma[k] = 0; mb[k] = 0; end
        @(posedge clk); #1;
        run(e, bc);
        check("postrst_sum16", 32'(sum16), 32'd0);
        check("postrst_carry16", 32'(carry16), 32'd0);
        check_all("postrst");

        // Randomised loads against the operand model
        reset_dut();
        for (int r = 0; r < 25; r++) begin
            int nl;
            nl = int'($urandom_range(1, 6));
            for (int j = 0; j < nl; j++)
                load(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            run(e, bc);
            check($sformatf("rnd%0d_edges", r), 32'(e), 32'd5);
            check_all($sformatf("rnd%0d", r));
        end

`ifdef SUBTRACT_EN
        reset_dut();
        sub = 1'b1;
        load(0, 0, 0); load(0, 1, 0); load(1, 0, 1); load(1, 1, 0);
        run(e, bc);
        check("sub_00_01_sum", 32'(sum8), 32'hFF);
        check("sub_00_01_carry", 32'(carry8), 32'd0);
        load(0, 0, 5); load(1, 0, 3);
        run(e, bc);
        check("sub_05_03_sum", 32'(sum8), 32'h02);
        check("sub_05_03_carry", 32'(carry8), 32'd1);
        sub = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Parametrised successor to the 7-bit push-button-loaded adder.
- Two WIDTH-bit operands are loaded CHUNK bits at a time from a shared data bus, on button-style strobes.
- The sum is computed serially, one CHUNK per clock, LSB-first, with carry chained between chunks.
- Results are registered, and a done flag is held. The block sits between the board's push-button/switch inputs and the display logic.

Parameters:
- WIDTH, 7, operand and sum width in bits (>=1).
- CHUNK, 4, bits per load slice and per add step (1..WIDTH).
- NCHUNK, derived localparam, ceil(WIDTH/CHUNK).
- SELW, derived localparam, max(1, clog2(NCHUNK)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_a  in  1  level strobe; a rising edge writes din into chunk sel of operand A.
- ld_b  in  1  level strobe; a rising edge writes din into chunk sel of operand B.
- sel  in  SELW  chunk index; 0 = bits [CHUNK-1:0].
- din  in  CHUNK  load data.
- start  in  1  level; a rising edge begins the addition.
- sum  out  WIDTH  registered result.
- carry  out  1  carry out of bit WIDTH-1.
- busy  out  1  high while the add is in progress.
- done  out  1  result valid; held high.

Behaviour:
- Reset is asynchronous and active-high:
  - A, B, sum, carry, busy, done all go to 0.
  - State goes to IDLE.
  - Edge-detect registers ld_a_q, ld_b_q, start_q go to 0.
  - Reset mid-BUSY aborts the add; the partial result is discarded.
- Edge detect: x_rise = x & ~x_q, where x_q is the previous-cycle sample. A strobe held high for many cycles acts exactly once.
- States: IDLE, BUSY, DONE.
- Loads are accepted in IDLE or DONE only:
  - On ld_a_rise, A[sel*CHUNK +: CHUNK] <= din. Bits at or beyond WIDTH are discarded, e.g. the top chunk for WIDTH=7/CHUNK=4 keeps din[2:0].
  - ld_b_rise does the same for B.
  - ld_a_rise and ld_b_rise in the same cycle both write.
  - sel >= NCHUNK: no write.
  - A load in DONE clears done and returns to IDLE; sum and carry keep their values.
  - Loads during BUSY are ignored, and their edge is consumed (x_q still updates).
- start_rise in IDLE or DONE:
  - State goes to BUSY, idx=0, c=0, done=0, busy=1.
  - If a load rise occurs in the same cycle, the load is written first and the add uses the new value.
  - start_rise during BUSY is ignored.
- BUSY, on each edge:
  - {c, work[idx]} <= A_chunk + B_chunk + c.
  - idx <= idx+1.
  - For the last chunk, the carry is taken from bit (WIDTH-1) mod CHUNK of the slice, not from the padded chunk MSB.
- After chunk NCHUNK-1 is processed:
  - sum <= work (with the last slice), carry <= c.
  - State goes to DONE, busy=0, done=1.
- Latency: done is high after exactly NCHUNK+1 rising edges, counting from the edge that sampled start_rise.
- Within DONE, sum and carry are stable. They update only on BUSY→DONE transitions or on reset.
- Arithmetic is unsigned modulo 2^WIDTH, with carry as bit WIDTH of the result.

Optional Feature:
- Macro SUBTRACT_EN.
- When defined:
  - An extra input port sub (1 bit) is added, sampled on start_rise.
  - With sub=1 the block computes A + ~B + 1: B chunks are inverted and c is initialised to 1.
  - carry=1 means no borrow (A >= B).
- When undefined: no sub port, and add only.

Decomposition:
- Package/include chunked_adder_defs:
  - state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - a clog2 constant function.
- Sub-module chunk_add:
  - combinational CHUNK-bit add, ports a, b, cin, s, cout;
  - exposes the per-bit carry vector for last-chunk carry selection;
  - instantiated once.
- The state machine, edge detects and registers stay in the top module.

Test Plan:
- Default params:
  - Load A: sel0=1101, sel1=0110. Load B: sel0=1110, sel1=0101.
  - Pulse start → done after 3 edges; sum=1001011, carry=1 (109+94=203).
- WIDTH=16:
  - A=16'hFFFF, B=16'h0001, start → sum=16'h0000, carry=1.
  - busy is high for exactly 4 cycles; done rises on the 5th edge.
- Hold ld_a high for 10 cycles while din changes 3→9 → A chunk holds 3 only.
  - Repeat with sel=2 at WIDTH=7 → A unchanged.
- Start, then assert ld_b and a second start rise mid-BUSY → both ignored; result equals the first operands.
  - Afterwards, raise ld_b in DONE → done=0, state IDLE, sum unchanged.
- Assert rst during the 2nd BUSY cycle → all outputs 0 asynchronously, before the next edge.
  - A and B cleared; a following start with no loads gives sum=0, carry=0.
- SUBTRACT_EN, WIDTH=8:
  - 8'h00-8'h01 → sum=8'hFF, carry=0.
  - 8'h05-8'h03 → sum=8'h02, carry=1.
